// File: rtl/led_pkg.sv
// led_pkg: shared state, pattern, rate types and pattern helpers for the LED scheduler
package led_pkg;
  typedef enum logic [1:0] {OFF, RUN, HOLD} state_t;
  typedef enum logic [1:0] {PAT_BLINK, PAT_LEFT, PAT_RIGHT, PAT_BOUNCE} pat_t;
  typedef logic [1:0] rate_t;
  localparam int TW = 28;
  localparam logic [2:0] LEN_BLINK = 3'd2;
  localparam logic [2:0] LEN_CHASE = 3'd4;
  localparam logic [2:0] LEN_BOUNCE = 3'd6;
  function automatic logic [TW-1:0] period(input logic [TW-1:0] base, input rate_t r);
    return base >> r;
  endfunction
  function automatic logic [2:0] pat_len(input pat_t p);
    return p == PAT_BLINK ? LEN_BLINK : p == PAT_BOUNCE ? LEN_BOUNCE : LEN_CHASE;
  endfunction
  function automatic logic [3:0] decode(input pat_t p, input logic [2:0] s);
    return p == PAT_BLINK ? {4{s[0]}} :
           p == PAT_LEFT  ? 4'b0001 << s[1:0] :
           p == PAT_RIGHT ? 4'b1000 >> s[1:0] :
           s[2] ? (s[0] ? 4'b0010 : 4'b0100) : 4'b0001 << s[1:0];
  endfunction
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: accepts a level after DEBOUNCE_CYCLES identical samples and pulses on each accepted rise
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic sample,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [CW-1:0] cnt;
  logic level;
  logic done;
  assign done = sample != level && cnt == CW'(DEBOUNCE_CYCLES - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      cnt <= (sample == level || done) ? '0 : cnt + 1'b1;
      level <= done ? sample : level;
      press <= done & sample;
    end
  end
endmodule

// File: rtl/led_pattern_scheduler.sv
// led_pattern_scheduler: button-selected rate, switch-selected LED pattern sequencer with run/hold/off control
module led_pattern_scheduler
  import led_pkg::*;
#(
  parameter int CLK_HZ = 100000000,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic       CLK100MHZ,
  input  logic       reset,
  input  logic [3:0] btn,
  input  logic [3:0] sw,
  output logic [3:0] led
);
  logic [3:0] btn_m, btn_s, sw_m, sw_s, press;
  state_t state;
  pat_t pat;
  rate_t rate_idx, pick;
  logic [TW-1:0] cnt, per;
  logic [2:0] step;
  logic tick, wrap, clear;
  genvar i;
  generate
    for (i = 0; i < 4; i++) begin : g_db
      btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
        .clk(CLK100MHZ), .rst(reset), .sample(btn_s[i]), .press(press[i])
      );
    end
  endgenerate
  assign per = period(TW'(CLK_HZ), rate_idx);
  assign tick = cnt == per - 1'b1;
  assign wrap = step == pat_len(pat) - 3'd1;
  assign pick = press[0] ? 2'd0 : press[1] ? 2'd1 : press[2] ? 2'd2 : 2'd3;
  assign clear = |press || pat_t'(sw_s[2:1]) != pat || state == OFF;
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      {btn_m, btn_s, sw_m, sw_s} <= '0;
      state <= OFF;
      pat <= PAT_BLINK;
      rate_idx <= '0;
      cnt <= '0;
      step <= '0;
      led <= '0;
    end else begin
      {btn_s, btn_m} <= {btn_m, btn};
      {sw_s, sw_m} <= {sw_m, sw};
      state <= !sw_s[0] ? OFF : state == OFF ? RUN : sw_s[3] ? HOLD : RUN;
      rate_idx <= |press ? pick : rate_idx;
      pat <= pat_t'(sw_s[2:1]);
      cnt <= clear ? '0 : state != RUN ? cnt : tick ? '0 : cnt + 1'b1;
      step <= clear ? '0 : (state != RUN || !tick) ? step : wrap ? '0 : step + 3'd1;
      led <= state == OFF ? '0 : state == HOLD ? led : decode(pat, step);
    end
  end
endmodule

// File: tb/tb_led_pattern_scheduler.sv
// tb_led_pattern_scheduler: scoreboard bench for the LED scheduler at CLK_HZ=16, DEBOUNCE_CYCLES=4
module tb_led_pattern_scheduler;
  import led_pkg::*;
  typedef struct {int at; logic [3:0] v;} exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0] btn = 4'b0000;
  logic [3:0] sw = 4'b0000;
  logic [3:0] led;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int mark = 0;
  exp_t exp_q[$];

  led_pattern_scheduler #(.CLK_HZ(16), .DEBOUNCE_CYCLES(4)) dut (
    .CLK100MHZ(clk), .reset(reset), .btn(btn), .sw(sw), .led(led)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void push_exp(input int at, input logic [3:0] v);
    exp_t e;
    e.at = at;
    e.v = v;
    exp_q.push_back(e);
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    sw = 4'b0000;
    btn = 4'b0000;
    repeat (3) @(negedge clk);
    checks++;
    if (led !== 4'b0000) begin errors++; $display("FAIL reset_led: led=%b want 0000", led); end
    checks++;
    if (dut.state !== OFF) begin errors++; $display("FAIL reset_state: state=%0d want %0d", dut.state, OFF); end
    checks++;
    if (dut.rate_idx !== 2'd0) begin errors++; $display("FAIL reset_rate: rate=%0d want 0", dut.rate_idx); end
  endtask

  task automatic test_blink();
    int b = cyc;
    exp_t e;
    reset = 1'b0;
    sw = 4'b0001;
    push_exp(b + 4, 4'b0000);
    push_exp(b + 19, 4'b0000);
    push_exp(b + 20, 4'b1111);
    push_exp(b + 35, 4'b1111);
    push_exp(b + 36, 4'b0000);
    push_exp(b + 52, 4'b1111);
    while (cyc < b + 52) begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].at == cyc) begin
        e = exp_q.pop_front();
        checks++;
        if (led !== e.v) begin errors++; $display("FAIL blink @%0d: led=%b want %b", cyc, led, e.v); end
      end
    end
  endtask

  task automatic test_rate_hold();
    int b = cyc;
    exp_t e;
    btn = 4'b1000;
    push_exp(b + 8, 4'b0000);
    push_exp(b + 9, 4'b0000);
    push_exp(b + 10, 4'b1111);
    push_exp(b + 11, 4'b1111);
    push_exp(b + 12, 4'b0000);
    push_exp(b + 14, 4'b1111);
    push_exp(b + 20, 4'b0000);
    push_exp(b + 22, 4'b1111);
    while (cyc < b + 30) begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].at == cyc) begin
        e = exp_q.pop_front();
        checks++;
        if (led !== e.v) begin errors++; $display("FAIL rate_hold @%0d: led=%b want %b", cyc, led, e.v); end
      end
      if (cyc == b + 12) begin
        checks++;
        if (dut.rate_idx !== 2'd3) begin errors++; $display("FAIL rate_hold_idx: rate=%0d want 3", dut.rate_idx); end
      end
      if (cyc == b + 10) btn = 4'b0000;
    end
  endtask

  task automatic test_simultaneous();
    int b = cyc;
    exp_t e;
    mark = b;
    btn = 4'b0101;
    push_exp(b + 8, 4'b0000);
    push_exp(b + 23, 4'b0000);
    push_exp(b + 24, 4'b1111);
    while (cyc < b + 26) begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].at == cyc) begin
        e = exp_q.pop_front();
        checks++;
        if (led !== e.v) begin errors++; $display("FAIL simultaneous @%0d: led=%b want %b", cyc, led, e.v); end
      end
      if (cyc == b + 10) begin
        checks++;
        if (dut.rate_idx !== 2'd0) begin errors++; $display("FAIL simultaneous_idx: rate=%0d want 0", dut.rate_idx); end
      end
      if (cyc == b + 8) btn = 4'b0000;
    end
  endtask

  task automatic test_glitch();
    exp_t e;
    push_exp(mark + 39, 4'b1111);
    push_exp(mark + 40, 4'b0000);
    push_exp(mark + 55, 4'b0000);
    push_exp(mark + 56, 4'b1111);
    while (cyc < mark + 56) begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].at == cyc) begin
        e = exp_q.pop_front();
        checks++;
        if (led !== e.v) begin errors++; $display("FAIL glitch @%0d: led=%b want %b", cyc, led, e.v); end
      end
      if (cyc == mark + 50) begin
        checks++;
        if (dut.rate_idx !== 2'd0) begin errors++; $display("FAIL glitch_idx: rate=%0d want 0", dut.rate_idx); end
      end
      if (cyc == mark + 30) btn = 4'b0010;
      if (cyc == mark + 32) btn = 4'b0000;
    end
  endtask

  task automatic test_chase_hold();
    int b = cyc;
    exp_t e;
    sw = 4'b0011;
    push_exp(b + 4, 4'b0001);
    push_exp(b + 20, 4'b0001);
    push_exp(b + 30, 4'b0001);
    push_exp(b + 39, 4'b0001);
    push_exp(b + 40, 4'b0010);
    push_exp(b + 56, 4'b0100);
    while (cyc < b + 56) begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].at == cyc) begin
        e = exp_q.pop_front();
        checks++;
        if (led !== e.v) begin errors++; $display("FAIL chase_hold @%0d: led=%b want %b", cyc, led, e.v); end
      end
      if (cyc == b + 15) begin
        checks++;
        if (dut.state !== HOLD) begin errors++; $display("FAIL chase_hold_state: state=%0d want %0d", dut.state, HOLD); end
      end
      if (cyc == b + 7) sw = 4'b1011;
      if (cyc == b + 27) sw = 4'b0011;
    end
  endtask

  task automatic test_bounce_off();
    int b = cyc;
    exp_t e;
    sw = 4'b0111;
    push_exp(b + 4, 4'b0001);
    push_exp(b + 19, 4'b0001);
    push_exp(b + 20, 4'b0010);
    push_exp(b + 36, 4'b0100);
    push_exp(b + 52, 4'b1000);
    push_exp(b + 68, 4'b0100);
    push_exp(b + 84, 4'b0010);
    push_exp(b + 99, 4'b0010);
    push_exp(b + 100, 4'b0001);
    push_exp(b + 109, 4'b0000);
    while (cyc < b + 109) begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].at == cyc) begin
        e = exp_q.pop_front();
        checks++;
        if (led !== e.v) begin errors++; $display("FAIL bounce_off @%0d: led=%b want %b", cyc, led, e.v); end
      end
      if (cyc == b + 109) begin
        checks++;
        if (dut.state !== OFF) begin errors++; $display("FAIL bounce_off_state: state=%0d want %0d", dut.state, OFF); end
      end
      if (cyc == b + 105) sw = 4'b0110;
    end
  endtask

  task automatic test_reset_mid_run();
    int b = cyc;
    exp_t e;
    sw = 4'b0001;
    push_exp(b + 17, 4'b1111);
    push_exp(b + 21, 4'b0000);
    push_exp(b + 25, 4'b1111);
    push_exp(b + 33, 4'b1111);
    push_exp(b + 34, 4'b0000);
    push_exp(b + 55, 4'b0000);
    push_exp(b + 56, 4'b1111);
    while (cyc < b + 56) begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].at == cyc) begin
        e = exp_q.pop_front();
        checks++;
        if (led !== e.v) begin errors++; $display("FAIL reset_mid_run @%0d: led=%b want %b", cyc, led, e.v); end
      end
      if (cyc == b + 25) begin
        checks++;
        if (dut.rate_idx !== 2'd2) begin errors++; $display("FAIL mid_run_idx: rate=%0d want 2", dut.rate_idx); end
      end
      if (cyc == b + 34) begin
        checks++;
        if (dut.state !== OFF) begin errors++; $display("FAIL mid_run_state: state=%0d want %0d", dut.state, OFF); end
        checks++;
        if (dut.rate_idx !== 2'd0) begin errors++; $display("FAIL mid_run_reset_idx: rate=%0d want 0", dut.rate_idx); end
      end
      if (cyc == b + 5) btn = 4'b0100;
      if (cyc == b + 15) btn = 4'b0000;
      if (cyc == b + 33) reset = 1'b1;
      if (cyc == b + 36) reset = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_blink();
    test_rate_hold();
    test_simultaneous();
    test_glitch();
    test_chase_hold();
    test_bounce_off();
    test_reset_mid_run();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/led_pattern_scheduler.md
LED_PATTERN_SCHEDULER -- requirements
Module: led_pattern_scheduler

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100000000; blink base count; rate 0 gives one step per CLK_HZ cycles.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 1000000; a button must be stable this many consecutive cycles before it is accepted.
REQ-003 SHALL have port CLK100MHZ, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port btn, input, 4 bits: asynchronous rate-select buttons, active-high.
REQ-006 SHALL have port sw, input, 4 bits: asynchronous switches; sw[0] enable, sw[2:1] pattern, sw[3] hold.
REQ-007 SHALL have port led, output, 4 bits: registered LED drive.

Function
REQ-008 SHALL pass every btn and sw bit through a 2-flop synchronizer before use.
REQ-009 SHALL debounce each synchronized btn bit: the level is accepted only after DEBOUNCE_CYCLES identical consecutive samples; any change restarts the count.
REQ-010 SHALL emit a one-cycle press pulse on each 0->1 transition of the accepted btn level; holding a button gives exactly one pulse.
REQ-011 SHALL set rate_idx to i on a press of btn[i]; on simultaneous presses the lowest index wins.
REQ-012 SHALL define period = CLK_HZ >> rate_idx, giving rates 0..3 = CLK_HZ, /2, /4, /8, with a 28-bit tick counter.
REQ-013 SHALL count the tick counter 0..period-1 and assert a tick when it equals period-1, wrapping to 0 on the same edge.
REQ-014 SHALL, on a press, clear the tick counter and step to 0 on the next edge, in any state.
REQ-015 SHALL implement an FSM with states OFF, RUN and HOLD.
- OFF -> RUN when sync sw[0]=1.
- RUN -> HOLD when sync sw[3]=1.
- HOLD -> RUN when sync sw[3]=0.
- Any state -> OFF when sync sw[0]=0, which has priority.
REQ-016 SHALL, in OFF, hold the counter and step at 0 and drive led=0000.
REQ-017 SHALL, in HOLD, freeze the counter, step and led; leaving HOLD resumes from the frozen count with no lost or extra cycle.
REQ-018 SHALL, in RUN, advance step by 1 per tick and wrap at the pattern length.
REQ-019 SHALL decode patterns by sw[2:1] as follows:
- 00 blink: length 2; step 0 = 0000, step 1 = 1111.
- 01 chase left: length 4; 0001, 0010, 0100, 1000.
- 10 chase right: length 4; 1000, 0100, 0010, 0001.
- 11 bounce: length 6; 0001, 0010, 0100, 1000, 0100, 0010.
REQ-020 SHALL, when the synchronized pattern value changes, clear the step and counter on the next edge.
REQ-021 SHALL register led as decode(pattern, step) with 1-cycle latency after a step change.
REQ-022 SHALL drive led=0000 within 4 edges of a raw sw[0] fall: 2 sync, 1 state, 1 led.
REQ-023 SHALL use a 3-bit step that never exceeds pattern length-1.

Reset
REQ-024 SHALL, on reset=1 at an edge, clear to 0 all synchronizers, debounce counters, accepted levels, rate_idx, tick counter and step, set the FSM to OFF and set led=0000; reset overrides all inputs.
REQ-025 SHALL, after reset deasserts, restart operation from these values with no residual press pulses.

Structure
REQ-026 SHALL place in the shared package led_pkg:
- FSM state encoding;
- pattern codes;
- the rate_idx type;
- the period computation function;
- the pattern-length constants.
REQ-027 SHALL implement debounce and edge detect in a sub-module btn_debounce, instantiated 4 times with parameter DEBOUNCE_CYCLES.

Verification (CLK_HZ=16, DEBOUNCE_CYCLES=4)
REQ-028 SHALL check: reset, then sw=0001 -> led 0000, then 1111 after 16 RUN cycles, then toggling every 16 cycles.
REQ-029 SHALL check: btn[3] held 10 cycles -> exactly one rate change; period becomes 2 and led toggles every 2 cycles; btn[0]+btn[2] pressed together -> rate 0.
REQ-030 SHALL check: btn[1] high for 2 cycles -> no rate change; counter phase undisturbed.
REQ-031 SHALL check: sw=0011 (chase left), then sw[3]=1 at count 7 for 20 cycles -> led constant; after release the next step arrives 9 cycles later.
REQ-032 SHALL check: sw=0111 (bounce) -> led sequence 0001, 0010, 0100, 1000, 0100, 0010, 0001; drop sw[0] -> led=0000 within 4 edges.
REQ-033 SHALL check: reset asserted mid-RUN at rate 2 -> next edge led=0000, state OFF, rate_idx 0.
